// File: rtl/seven_seg_rx.sv
// Receive-side monitor for a scanned 7-segment bus: waits for each digit slot
// to settle, decodes it back to hex and emits a full 4-digit frame with a strobe.
module seven_seg_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEGMENT,
  output logic [15:0] hex_value,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic [3:0]  bad,
  output logic [31:0] raw_seg,
  output logic        frame_valid
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {WAIT_AN, SETTLE, HOLD} state_t;

  state_t             state;
  logic [3:0]         an_q;
  logic [7:0]         seg_q;
  logic [3:0]         ref_an;
  logic [7:0]         ref_seg;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         seen;
  logic [31:0]        slot_raw;
  logic [15:0]        slot_nib;
  logic [3:0]         slot_dp;
  logic [3:0]         slot_blank;
  logic [3:0]         slot_bad;

  logic               an_valid_c;
  logic [1:0]         idx_c;
  logic               match_c;
  logic               entry_c;
  logic               settle_hit_c;
  logic               capture_c;
  logic [5:0]         dec_c;

  // Exactly one active-low enable selects a digit; anything else is idle/invalid.
  function automatic logic [2:0] an_index(input logic [3:0] an);
    case (an)
      4'b1110: an_index = 3'b100;
      4'b1101: an_index = 3'b101;
      4'b1011: an_index = 3'b110;
      4'b0111: an_index = 3'b111;
      default: an_index = 3'b000;
    endcase
  endfunction

  // Returns {bad, blank, nibble} for the g..a lines.
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = 6'h00;
      7'h79: seg_decode = 6'h01;
      7'h24: seg_decode = 6'h02;
      7'h30: seg_decode = 6'h03;
      7'h19: seg_decode = 6'h04;
      7'h12: seg_decode = 6'h05;
      7'h02: seg_decode = 6'h06;
      7'h78: seg_decode = 6'h07;
      7'h00: seg_decode = 6'h08;
      7'h10: seg_decode = 6'h09;
      7'h08: seg_decode = 6'h0A;
      7'h03: seg_decode = 6'h0B;
      7'h46: seg_decode = 6'h0C;
      7'h21: seg_decode = 6'h0D;
      7'h06: seg_decode = 6'h0E;
      7'h0E: seg_decode = 6'h0F;
      7'h7F: seg_decode = 6'h10;
      default: seg_decode = 6'h20;
    endcase
  endfunction

  assign {an_valid_c, idx_c} = an_index(an_q);
  assign match_c      = ({an_q, seg_q} == {ref_an, ref_seg});
  assign entry_c      = an_valid_c && ((state == WAIT_AN) || !match_c);
  assign settle_hit_c = (state == SETTLE) && match_c &&
                        ((9'(cnt) + 9'd1) >= 9'(STABLE_CYCLES));
  assign capture_c    = settle_hit_c || (entry_c && (STABLE_CYCLES == 1));
  assign dec_c        = seg_decode(seg_q[6:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_AN;
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
      ref_an      <= 4'hF;
      ref_seg     <= 8'hFF;
      cnt         <= '0;
      seen        <= '0;
      slot_raw    <= 32'hFFFF_FFFF;
      slot_nib    <= '0;
      slot_dp     <= '0;
      slot_blank  <= '0;
      slot_bad    <= '0;
      hex_value   <= '0;
      dp          <= '0;
      blank       <= '0;
      bad         <= '0;
      raw_seg     <= 32'hFFFF_FFFF;
      frame_valid <= 1'b0;
    end else begin
      an_q        <= AN;
      seg_q       <= SEGMENT;
      frame_valid <= 1'b0;

      // Settle tracking: reload on any change to a valid digit, drop out on invalid.
      if (entry_c) begin
        ref_an  <= an_q;
        ref_seg <= seg_q;
        cnt     <= CNT_W'(1);
        state   <= (STABLE_CYCLES == 1) ? HOLD : SETTLE;
      end else if ((state != WAIT_AN) && !match_c) begin
        state <= WAIT_AN;
      end else if (state == SETTLE) begin
        cnt <= cnt + CNT_W'(1);
        if (settle_hit_c) state <= HOLD;
      end

      for (int i = 0; i < 4; i++) begin
        if (capture_c && (idx_c == 2'(i))) begin
          slot_raw[8*i +: 8]   <= seg_q;
          slot_nib[4*i +: 4]   <= dec_c[3:0];
          slot_dp[i]           <= ~seg_q[7];
          slot_blank[i]        <= dec_c[4];
          slot_bad[i]          <= dec_c[5];
        end
      end

      // A full mask is published one cycle after the completing capture.
      if (seen == 4'hF) begin
        hex_value   <= slot_nib;
        dp          <= slot_dp;
        blank       <= slot_blank;
        bad         <= slot_bad;
        raw_seg     <= slot_raw;
        frame_valid <= 1'b1;
      end
      seen <= ((seen == 4'hF) ? 4'h0 : seen) |
              (capture_c ? (4'b0001 << idx_c) : 4'h0);
    end
  end

endmodule

// File: doc/seven_seg_rx.md
Name: seven_seg_rx

Overview:
- Receive-side monitor for the scanned 7-segment bus driven by `seven_seg_dev`.
- Samples the multiplexed AN/SEGMENT lines and waits for each digit slot to settle.
- Latches each digit's segment pattern, decodes it back to a hex nibble, and presents a complete 4-digit frame with a one-cycle strobe.
- Used in self-checking benches and on-chip loopback to reconstruct the displayed value.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical samples of AN+SEGMENT required before a digit is captured (range 1..255).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- AN  input  4  digit enables, active-low; AN[0] = rightmost digit
- SEGMENT  input  8  segment lines, active-low; [7]=dp, [6]=g, [5]=f, ..., [0]=a
- hex_value  output  16  decoded frame; digit i occupies [4i+3:4i]
- dp  output  4  per-digit decimal point, active-high (1 = dp lit)
- blank  output  4  per-digit flag: all of g..a off (SEGMENT[6:0]=7'h7F)
- bad  output  4  per-digit flag: pattern is neither a hex glyph nor blank
- raw_seg  output  32  raw captured SEGMENT byte per digit, digit i at [8i+7:8i]
- frame_valid  output  1  one-cycle pulse when hex_value, dp, blank, bad and raw_seg update

Behaviour:
- Reset values:
  - hex_value=0, dp=0, blank=0, bad=0, frame_valid=0.
  - raw_seg=32'hFFFF_FFFF.
  - Internal seen mask=0, settle counter=0, FSM=WAIT_AN.
- AN validity: AN is valid only when exactly one bit is 0. AN=4'hF, or two or more bits 0, is invalid.
- Sample register: AN and SEGMENT are registered once on entry (1 cycle). All comparisons use the registered copies.
- FSM states:
  - WAIT_AN: registered AN invalid → stay. Valid → load the sample into ref, set counter=1, go to SETTLE.
  - SETTLE:
    - Sample differs from ref, new AN valid → reload ref, counter=1, stay.
    - Sample differs from ref, new AN invalid → WAIT_AN.
    - Sample equals ref → counter+1.
    - Capture condition: counter reaches STABLE_CYCLES, or STABLE_CYCLES=1 on the entry cycle.
    - On capture: write the slot, set seen[i], go to HOLD.
  - HOLD: sample equals ref → stay (no recapture). Any change → same action as a SETTLE mismatch.
- Slot write for digit i (i = index of the low AN bit):
  - raw slot = SEGMENT.
  - dp_slot = ~SEGMENT[7].
  - Decode SEGMENT[6:0] → nibble:
    - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
    - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F → nibble 0, blank=1.
  - Any other pattern → nibble 0, bad=1.
  - Recapturing a slot already in seen overwrites it; seen is unchanged.
- Frame assembly:
  - On the cycle after a capture that makes seen=4'hF, all slot data is copied to the outputs, frame_valid=1 for exactly one cycle, and seen is cleared.
  - A capture in that same cycle (possible only when STABLE_CYCLES=1) is written to its slot and sets the bit in the freshly cleared mask.
- Outputs hold their values between frames.
- Latency: the last digit becoming stable on the pins produces frame_valid after 1 (input reg) + STABLE_CYCLES + 1 cycles.
- Reset mid-operation: all state returns to reset values on the next edge. A partial frame is discarded. No frame_valid is emitted during reset or on the edge leaving reset.
- Ghosting: a transient shorter than STABLE_CYCLES never captures.

Test Plan:
- Reset then scan AN=E,D,B,7 with SEGMENT=80,F8,82,92, each held 8 cycles (STABLE_CYCLES=4) → single frame_valid pulse; hex_value=16'h5678, dp=0, blank=0, bad=0, raw_seg=32'h9282F880.
- Same scan with SEGMENT=40,79,24,30 repeated for 3 passes → exactly 3 frame_valid pulses, each hex_value=16'h3210.
- Scan with digit 2 SEGMENT=FF (blinking off phase) and digit 0 SEGMENT=7F (dp lit on '0'... no, blank with dp) → blank=4'b0101, dp=4'b0001, hex_value nibbles 2 and 0 read 0.
- Digit 1 SEGMENT=8'hAA (not a glyph) → bad=4'b0010, hex_value[7:4]=0, raw_seg[15:8]=8'hAA.
- Digit held only 2 cycles, plus AN=4'b1100 for 10 cycles → no capture for those intervals; frame_valid only after all four digits are validly held for ≥4 cycles.
- Assert rst after 3 digits captured, then release and scan 4 digits → no pulse during or at reset exit; exactly one pulse after the full post-reset scan, with the new values.
